dmem_bank: RTL and testbench

Parametrised, byte-addressed data memory for the CPU load/store stage. Supports byte, half-word and word accesses with byte-lane writes and sign/zero-extended loads. Uses a req/ready/valid handshake and a configurable number of wait states, so the pipeline can model slower memories. Contents are not initialised by reset.

---
 rtl/dmem_bank.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bank.sv
// dmem_bank: byte-addressed data memory for the CPU load/store stage.
//
// Word-organised array (DEPTH x 32 bit) with byte-lane writes and
// sign/zero-extended byte/half loads. A request is accepted while idle.
// The access happens WAIT_CYCLES edges later, followed by a single-cycle
// valid_o pulse. Array contents are not cleared by reset.
//
// Configuration macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are flagged on err_o.
//               They do not write memory and they return rdata_o = 0.
//   undefined - address bits below the access size are forced to zero.
//               err_o is tied low.
//
// Ports:
//   clk_i      in   1       clock, rising edge
//   rst_i      in   1       synchronous active-high reset
//   req_i      in   1       request, sampled only while ready_o = 1
//   we_i       in   1       1 = store, 0 = load
//   size_i     in   2       00 byte, 01 half, 10/11 word
//   unsigned_i in   1       loads: 1 = zero-extend, 0 = sign-extend
//   addr_i     in   ADDR_W  byte address (wraps modulo DEPTH*4)
//   wdata_i    in   32      store data, right-aligned
//   ready_o    out  1       idle, request accepted
//   valid_o    out  1       one-cycle completion pulse
//   rdata_o    out  32      load result, held until the next completed load
//   err_o      out  1       misaligned access, qualified by valid_o
`timescale 1ns/1ps
module dmem_bank #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic             we_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic [IDX_W+1:0] addr_r;
    logic [31:0]      wdata_r;
    logic [31:0]      mem_r [DEPTH];

    logic [IDX_W-1:0] idx_s;
    logic [1:0]       lane_s;
    logic             misalign_s;
    logic             access_s;
    logic [3:0]       be_s;
    logic [31:0]      wd_s;
    logic [31:0]      load_s;

    // Bytes enabled by a store of the given size at the given lane.
    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001 << lane;
            2'b01:   mask = lane[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Store data replicated so that every candidate lane sees the right bytes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] data;
        case (size)
            2'b00:   data = {4{wd[7:0]}};
            2'b01:   data = {2{wd[15:0]}};
            default: data = wd;
        endcase
        return data;
    endfunction

    // Shift the addressed byte/half down to bit 0 and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{24{~uns & shifted[7]}}, shifted[7:0]};
            2'b01:   res = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
    // A half must sit on an even address and a word on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction
`else
    // Drop the address bits below the access size.
    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
        logic [1:0] res;
        case (size)
            2'b00:   res = lane;
            2'b01:   res = {lane[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction
`endif

    // Address bits above the array are ignored, so the array wraps.
    if (ADDR_W > IDX_W + 2) begin : g_hi_addr
        logic unused_hi_addr_s;
        assign unused_hi_addr_s = ^addr_i[ADDR_W-1:IDX_W+2];
    end

    // Decode the captured request into array index, lane, byte enables and load result.
    always_comb begin
        idx_s = addr_r[IDX_W+1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
        lane_s     = addr_r[1:0];
        misalign_s = is_misaligned(size_r, addr_r[1:0]);
`else
        lane_s     = align_lane(size_r, addr_r[1:0]);
        misalign_s = 1'b0;
`endif
        access_s = (state_r == ST_BUSY) && (cnt_r == 4'd0);
        be_s     = store_mask(size_r, lane_s);
        wd_s     = store_data(size_r, wdata_r);
        load_s   = load_extract(mem_r[idx_s], size_r, lane_s, uns_r);
    end

    // Array write port: reset at the access edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (access_s && we_r && !misalign_s && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: capture request, count wait states, access, respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            rdata_o <= 32'd0;
            err_o   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_o <= 1'b0;
                    err_o   <= 1'b0;
                    if (req_i) begin
                        we_r    <= we_i;
                        size_r  <= size_i;
                        uns_r   <= unsigned_i;
                        addr_r  <= addr_i[IDX_W+1:0];
                        wdata_r <= wdata_i;
                        cnt_r   <= 4'(WAIT_CYCLES);
                        ready_o <= 1'b0;
                        state_r <= ST_BUSY;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        valid_o <= 1'b1;
                        err_o   <= misalign_s;
                        // A flagged access returns zero; a good store leaves the last load result.
                        if (misalign_s) begin
                            rdata_o <= 32'd0;
                        end else if (!we_r) begin
                            rdata_o <= load_s;
                        end else begin
                            rdata_o <= rdata_o;
                        end
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    valid_o <= 1'b0;
                    err_o   <= 1'b0;
                    ready_o <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_o <= 1'b0;
                    err_o   <= 1'b0;
                    ready_o <= 1'b1;
                    cnt_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// Self-checking bench for dmem_bank: one instance with zero wait states and one with three.
// Expectations are queued when a request is driven and compared when valid_o pulses.
`timescale 1ns/1ps
module tb_dmem_bank;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req0, req3, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready0, valid0, err0, ready3, valid3, err3;
    logic [31:0] rdata0, rdata3;

    always #5 clk = ~clk;

    dmem_bank #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .size_i(size), .unsigned_i(uns),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready0), .valid_o(valid0), .rdata_o(rdata0),
        .err_o(err0)
    );

    dmem_bank #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we), .size_i(size), .unsigned_i(uns),
        .addr_i(addr), .wdata_i(wdata), .ready_o(ready3), .valid_o(valid3), .rdata_o(rdata3),
        .err_o(err3)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];
    exp_t        m0, m3, hold_e;
    logic [31:0] last_rd [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard for the zero-wait instance.
    always @(negedge clk) begin
        if (valid0) begin
            if (q0.size() == 0) begin
                check_eq("unexpected_valid0", {31'd0, valid0}, 32'd0);
            end else begin
                m0 = q0.pop_front();
                check_eq("rdata0", rdata0, m0.rd);
                check_eq("err0", {31'd0, err0}, {31'd0, m0.err});
            end
        end
    end

    // Scoreboard for the three-wait instance.
    always @(negedge clk) begin
        if (valid3) begin
            if (q3.size() == 0) begin
                check_eq("unexpected_valid3", {31'd0, valid3}, 32'd0);
            end else begin
                m3 = q3.pop_front();
                check_eq("rdata3", rdata3, m3.rd);
                check_eq("err3", {31'd0, err3}, {31'd0, m3.err});
            end
        end
    end

    // One complete access: wait for ready, queue the expectation, drive one cycle, check latency.
    task automatic access(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   vk;
        int   rk;
        int   lat;
        lat = sel ? 3 : 0;
        for (int i = 0; i < 40; i++) begin
            if ((sel ? ready3 : ready0) === 1'b1) break;
            @(negedge clk);
        end
        if ((sel ? ready3 : ready0) !== 1'b1) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            return;
        end
        e.err = exp_err;
        if (exp_err) e.rd = 32'd0;
        else if (w) e.rd = last_rd[sel];
        else e.rd = exp_rd;
        last_rd[sel] = e.rd;
        if (sel) q3.push_back(e);
        else q0.push_back(e);
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        if (sel) req3 = 1'b1;
        else req0 = 1'b1;
        vk = 0;
        rk = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble the inputs once the request has been captured.
                req0 = 1'b0; req3 = 1'b0;
                we = ~w; size = ~sz; uns = ~u; addr = ~a; wdata = ~wd;
            end
            if ((sel ? valid3 : valid0) && vk == 0) vk = k;
            if (sel ? ready3 : ready0) begin
                rk = k;
                break;
            end
        end
        check_eq("latency_valid", 32'(vk), 32'(lat + 2));
        check_eq("latency_ready", 32'(rk), 32'(lat + 3));
    endtask

    initial begin
        int          nv;
        int          vk1;
        int          vk2;
        logic [31:0] w;
        logic [31:0] w2;
        logic [31:0] b;
        logic [7:0]  bb;
        logic [1:0]  l;
        logic [1:0]  m;
        logic [31:0] a;

        rst = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0; uns = 1'b0;
        size = 2'b00; addr = 32'd0; wdata = 32'd0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        // Reset for two cycles, with a request present in the second.
        @(negedge clk);
        check_eq("rst_ready0", {31'd0, ready0}, 32'd1);
        check_eq("rst_valid0", {31'd0, valid0}, 32'd0);
        check_eq("rst_rdata0", rdata0, 32'd0);
        check_eq("rst_err0", {31'd0, err0}, 32'd0);
        req0 = 1'b1; req3 = 1'b1;
        @(negedge clk);
        check_eq("rst_ready3", {31'd0, ready3}, 32'd1);
        check_eq("rst_valid3", {31'd0, valid3}, 32'd0);
        check_eq("rst_rdata3", rdata3, 32'd0);
        rst = 1'b0; req0 = 1'b0; req3 = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (valid0 || valid3) nv++;
        end
        check_eq("rst_req_dropped", 32'(nv), 32'd0);
        check_eq("post_rst_ready0", {31'd0, ready0}, 32'd1);

        // Word store/load and byte lanes on the zero-wait instance.
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, 32'd0, 1'b0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD5AEF, 1'b0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'h0000DEAD, 1'b0);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFFDEAD, 1'b0);
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 32'h0000005A, 1'b0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hFFFFFFEF, 1'b0);
        access(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'hDEAD5AEF, 1'b0);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA1234, 32'd0, 1'b0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h12345AEF, 1'b0);

        // Misaligned word store and half load.
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h12345678, 32'd0, MIS);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, MIS ? 32'hCAFEF00D : 32'h12345678, 1'b0);
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h21, 32'd0, MIS ? 32'd0 : 32'h00005678, MIS);

        // Address wrap: 0x400 aliases word 0.
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0BADF00D, 32'd0, 1'b0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h000, 32'd0, 32'h0BADF00D, 1'b0);

        // Random word store, byte overwrite, signed byte and word readback.
        for (int i = 0; i < 12; i++) begin
            w = $urandom;
            b = $urandom;
            l = 2'($urandom_range(3, 0));
            m = 2'($urandom_range(3, 0));
            a = 32'h100 + 32'(i * 4);
            w2 = w;
            w2[8*l +: 8] = b[7:0];
            bb = w2[8*m +: 8];
            access(1'b0, 1'b1, 2'b10, 1'b0, a, w, 32'd0, 1'b0);
            access(1'b0, 1'b1, 2'b00, 1'b0, a + 32'(l), b, 32'd0, 1'b0);
            access(1'b0, 1'b0, 2'b00, 1'b0, a + 32'(m), 32'd0, {{24{bb[7]}}, bb}, 1'b0);
            access(1'b0, 1'b0, 2'b10, 1'b0, a, 32'd0, w2, 1'b0);
        end

        // Wait states on the three-wait instance.
        access(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111, 32'd0, 1'b0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h11111111, 1'b0);

        // req held high through two back-to-back loads.
        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'd0;
        hold_e.rd = 32'h11111111;
        hold_e.err = 1'b0;
        q3.push_back(hold_e);
        q3.push_back(hold_e);
        req3 = 1'b1;
        nv = 0; vk1 = 0; vk2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 7) req3 = 1'b0;
            if (valid3) begin
                nv++;
                if (vk1 == 0) vk1 = k;
                else vk2 = k;
            end
            if (k == 1) check_eq("hold_ready_busy1", {31'd0, ready3}, 32'd0);
            if (k == 6) check_eq("hold_ready_back", {31'd0, ready3}, 32'd1);
            if (k == 7) check_eq("hold_ready_busy2", {31'd0, ready3}, 32'd0);
            if (k == 12) check_eq("hold_ready_end", {31'd0, ready3}, 32'd1);
        end
        check_eq("hold_valid_first", 32'(vk1), 32'd5);
        check_eq("hold_valid_second", 32'(vk2), 32'd11);
        check_eq("hold_valid_count", 32'(nv), 32'd2);

        // Reset landing on the access edge of a store: no write, no response.
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'h22222222;
        req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid3) nv++;
        end
        check_eq("rst_busy_no_valid", 32'(nv), 32'd0);
        check_eq("rst_busy_rdata", rdata3, 32'd0);
        check_eq("rst_busy_ready", {31'd0, ready3}, 32'd1);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h11111111, 1'b0);

        repeat (4) @(negedge clk);
        check_eq("queue0_drained", 32'(q0.size()), 32'd0);
        check_eq("queue3_drained", 32'(q3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
